// File: rtl/sse_feeder_pkg.sv
// rtl/sse_feeder_pkg.sv - shared types, constants and helpers for the SSE pair feeder.
package sse_feeder_pkg;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LAST = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
  } pair_entry_t;

  // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_fp_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/sse_pair_fifo.sv
// rtl/sse_pair_fifo.sv - synchronous FIFO of pair_entry_t with pointer/occupancy bookkeeping.
module sse_pair_fifo
  import sse_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  pair_entry_t din_i,
  input  logic        pop_i,
  output pair_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pair_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head is read combinationally; the consumer registers it on pop.
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sse_pair_feeder.sv
// rtl/sse_pair_feeder.sv - buffers (A,B) fp32 pairs and serves them to the SSE on next/stop.
// Optional NaN scrubbing on write and nan_count port under SSE_FEEDER_NAN_SCRUB_EN.
module sse_pair_feeder
  import sse_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_a,
  input  logic [31:0]   wr_b,
  input  logic          wr_last,
  output logic          wr_full,
  input  logic          next,
  output logic [31:0]   a_out,
  output logic [31:0]   b_out,
  output logic          stop,
`ifdef SSE_FEEDER_NAN_SCRUB_EN
  output logic [7:0]    nan_count,
`endif
  output logic          underflow,
  output logic [CW-1:0] pair_count
);

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          stop_q, stop_d;
  logic          uf_q, uf_d;
  logic [CW-1:0] pc_q, pc_d;

  logic          fifo_full, fifo_empty, push, pop;
  pair_entry_t   head, wr_entry;
  logic [31:0]   a_wr, b_wr;

  assign wr_full = fifo_full || (state_q == S_STOP);
  assign push    = wr_en && !wr_full;

`ifdef SSE_FEEDER_NAN_SCRUB_EN
  logic       nan_a, nan_b;
  logic [7:0] nan_q, nan_d;
  logic [8:0] nan_sum;

  always_comb begin
    nan_a   = is_fp_nan(wr_a);
    nan_b   = is_fp_nan(wr_b);
    a_wr    = nan_a ? FP_ZERO : wr_a;
    b_wr    = nan_b ? FP_ZERO : wr_b;
    nan_sum = {1'b0, nan_q} + 9'(nan_a) + 9'(nan_b);
    nan_d   = nan_q;
    if (push) nan_d = (nan_sum > 9'd255) ? 8'hFF : nan_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) nan_q <= 8'd0;
    else     nan_q <= nan_d;
  end

  assign nan_count = nan_q;
`else
  assign a_wr = wr_a;
  assign b_wr = wr_b;
`endif

  assign wr_entry = '{last: wr_last, a: a_wr, b: b_wr};

  sse_pair_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (wr_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    stop_d  = stop_q;
    uf_d    = uf_q;
    pc_d    = pc_q;
    pop     = 1'b0;
    case (state_q)
      S_RUN: begin
        if (next) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            a_d  = head.a;
            b_d  = head.b;
            pc_d = pc_q + CW'(1);
            if (head.last) state_d = S_LAST;
          end else begin
            // Starved request: feed zeros so the SSE accumulates nothing.
            a_d  = FP_ZERO;
            b_d  = FP_ZERO;
            uf_d = 1'b1;
          end
        end
      end
      S_LAST: begin
        if (next) begin
          stop_d  = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      a_q     <= FP_ZERO;
      b_q     <= FP_ZERO;
      stop_q  <= 1'b0;
      uf_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stop_q  <= stop_d;
      uf_q    <= uf_d;
      pc_q    <= pc_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign stop       = stop_q;
  assign underflow  = uf_q;
  assign pair_count = pc_q;

endmodule

// File: tb/tb_sse_pair_feeder.sv
// tb/tb_sse_pair_feeder.sv - directed self-checking bench for sse_pair_feeder.
module tb_sse_pair_feeder;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr_last, next;
  logic [31:0] wr_a, wr_b, a_out, b_out;
  logic        wr_full, stop, underflow;
  logic [15:0] pair_count;
`ifdef SSE_FEEDER_NAN_SCRUB_EN
  logic [7:0]  nan_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sse_pair_feeder #(
    .DEPTH (16),
    .AW    (4),
    .CW    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .wr_last    (wr_last),
    .wr_full    (wr_full),
    .next       (next),
    .a_out      (a_out),
    .b_out      (b_out),
    .stop       (stop),
`ifdef SSE_FEEDER_NAN_SCRUB_EN
    .nan_count  (nan_count),
`endif
    .underflow  (underflow),
    .pair_count (pair_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic last);
    wr_en   = 1'b1;
    wr_a    = a;
    wr_b    = b;
    wr_last = last;
    tick(1);
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic pulse();
    next = 1'b1;
    tick(1);
    next = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_last = 1'b0; next = 1'b0;
    wr_a = 32'd0; wr_b = 32'd0;
    tick(3);
    rst = 1'b0;

    // Reset state
    chk("rst_a", a_out, 32'h0);
    chk("rst_b", b_out, 32'h0);
    chk("rst_stop", {31'd0, stop}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_pc", {16'd0, pair_count}, 32'd0);
    chk("rst_full", {31'd0, wr_full}, 32'd0);

    // Three-pair frame, four requests 5 cycles apart
    push(32'h3F80_0000, 32'h0000_0000, 1'b0);
    push(32'h4000_0000, 32'h3F80_0000, 1'b0);
    push(32'h4040_0000, 32'h4000_0000, 1'b1);
    pulse();
    chk("f1_a", a_out, 32'h3F80_0000);
    chk("f1_b", b_out, 32'h0000_0000);
    chk("f1_pc", {16'd0, pair_count}, 32'd1);
    tick(4);
    pulse();
    chk("f2_a", a_out, 32'h4000_0000);
    chk("f2_b", b_out, 32'h3F80_0000);
    tick(4);
    pulse();
    chk("f3_a", a_out, 32'h4040_0000);
    chk("f3_b", b_out, 32'h4000_0000);
    chk("f3_pc", {16'd0, pair_count}, 32'd3);
    chk("f3_stop", {31'd0, stop}, 32'd0);
    tick(4);
    pulse();
    chk("f4_stop", {31'd0, stop}, 32'd1);
    chk("f4_a_hold", a_out, 32'h4040_0000);
    chk("f4_pc", {16'd0, pair_count}, 32'd3);
    chk("f4_full", {31'd0, wr_full}, 32'd1);
    pulse();
    chk("f5_pc_ignored", {16'd0, pair_count}, 32'd3);

    // Fill to DEPTH, drop the 17th, drain in order with next held high
    do_reset();
    for (int i = 0; i < 16; i++) push(32'h1000_0000 + i, 32'h2000_0000 + i, 1'b0);
    chk("fill_full", {31'd0, wr_full}, 32'd1);
    push(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    next = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("drain_a", a_out, 32'h1000_0000 + i);
      chk("drain_b", b_out, 32'h2000_0000 + i);
    end
    next = 1'b0;
    chk("drain_full", {31'd0, wr_full}, 32'd0);
    chk("drain_pc", {16'd0, pair_count}, 32'd16);
    chk("drain_uf0", {31'd0, underflow}, 32'd0);
    pulse();
    chk("drain_empty_uf", {31'd0, underflow}, 32'd1);
    chk("drain_empty_a", a_out, 32'h0);
    chk("drain_empty_pc", {16'd0, pair_count}, 32'd16);

    // Underflow on empty, then normal delivery
    do_reset();
    pulse();
    chk("uf_a", a_out, 32'h0);
    chk("uf_b", b_out, 32'h0);
    chk("uf_flag", {31'd0, underflow}, 32'd1);
    chk("uf_pc", {16'd0, pair_count}, 32'd0);
    push(32'h4000_0000, 32'h3F80_0000, 1'b0);
    pulse();
    chk("uf_then_a", a_out, 32'h4000_0000);
    chk("uf_then_b", b_out, 32'h3F80_0000);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);

    // Same-cycle write and next on empty FIFO: no bypass
    do_reset();
    wr_en = 1'b1; wr_a = 32'h4040_0000; wr_b = 32'h4080_0000; next = 1'b1;
    tick(1);
    wr_en = 1'b0; next = 1'b0;
    chk("byp_uf", {31'd0, underflow}, 32'd1);
    chk("byp_a", a_out, 32'h0);
    chk("byp_pc", {16'd0, pair_count}, 32'd0);
    pulse();
    chk("byp_next_a", a_out, 32'h4040_0000);
    chk("byp_next_b", b_out, 32'h4080_0000);

    // Reset mid-frame, then a fresh one-pair frame
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h3000_0000 + i, 32'h3100_0000 + i, i == 4);
    pulse();
    pulse();
    chk("mid_a", a_out, 32'h3000_0001);
    do_reset();
    chk("mid_rst_a", a_out, 32'h0);
    chk("mid_rst_b", b_out, 32'h0);
    chk("mid_rst_pc", {16'd0, pair_count}, 32'd0);
    chk("mid_rst_stop", {31'd0, stop}, 32'd0);
    chk("mid_rst_full", {31'd0, wr_full}, 32'd0);
    push(32'h4100_0000, 32'h4110_0000, 1'b1);
    pulse();
    chk("fresh_a", a_out, 32'h4100_0000);
    chk("fresh_b", b_out, 32'h4110_0000);
    chk("fresh_pc", {16'd0, pair_count}, 32'd1);
    pulse();
    chk("fresh_stop", {31'd0, stop}, 32'd1);
    chk("fresh_uf", {31'd0, underflow}, 32'd0);

`ifdef SSE_FEEDER_NAN_SCRUB_EN
    do_reset();
    push(32'h7FC0_0000, 32'h7F80_0000, 1'b0);
    pulse();
    chk("nan_a", a_out, 32'h0000_0000);
    chk("nan_b_inf", b_out, 32'h7F80_0000);
    chk("nan_cnt", {24'd0, nan_count}, 32'd1);
`endif

    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
